// File: rtl/bike_pkg.sv
// Shared definitions for the bike computer arithmetic blocks.
// Covers the divider width, its state encoding and the layout of the divider bus.
package bike_pkg;

    localparam int DIV_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Field positions within the 2*DIV_W divider bus
    localparam int DIVIDEND_MSB = 2*DIV_W - 1;
    localparam int DIVIDEND_LSB = DIV_W;
    localparam int DIVISOR_MSB  = DIV_W - 1;
    localparam int DIVISOR_LSB  = 0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {P,Q} left by one bit, then do a
// trial subtract of D and keep the result only when it does not borrow.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   p_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] d_ext;
    logic             no_borrow;

    assign shifted   = {p, q[WIDTH-1]};
    assign d_ext     = {2'b00, d};
    assign no_borrow = (shifted >= d_ext);

    // The partial remainder always stays below 2*D, so it fits in WIDTH+1 bits.
    assign p_next = no_borrow ? (WIDTH+1)'(shifted - d_ext) : (WIDTH+1)'(shifted);
    assign q_next = {q[WIDTH-2:0], no_borrow};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider. It produces one quotient bit per clock
// and signals completion with a one-cycle ready pulse.
module seq_divider
    import bike_pkg::*;
#(
    parameter int WIDTH = DIV_W,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               r,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividerbus,
    output logic [WIDTH-1:0]   dividerres,
    output logic [WIDTH-1:0]   remainder,
    output logic               busy,
    output logic               ready,
    output logic               div_zero
);

    div_state_t       state_reg, state_next;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] bus_dividend;
    logic [WIDTH-1:0] bus_divisor;

    assign bus_dividend = dividerbus[2*WIDTH-1:WIDTH];
    assign bus_divisor  = dividerbus[WIDTH-1:0];

    div_step #(.WIDTH(WIDTH)) u_step (
        .p      (p_reg),
        .q      (q_reg),
        .d      (d_reg),
        .p_next (p_next),
        .q_next (q_next)
    );

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (bus_divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                // Leave on the edge where the counter reaches zero.
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            p_reg      <= '0;
            q_reg      <= '0;
            d_reg      <= '0;
            cnt_reg    <= '0;
            dividerres <= '0;
            remainder  <= '0;
            busy       <= 1'b0;
            ready      <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        q_reg   <= bus_dividend;
                        d_reg   <= bus_divisor;
                        p_reg   <= '0;
                        cnt_reg <= CNT_W'(WIDTH);
                        busy    <= 1'b1;
                    end
                end
                CALC: begin
                    p_reg   <= p_next;
                    q_reg   <= q_next;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
                DONE: begin
                    // On a zero divisor Q was never shifted, so it still holds the dividend.
                    if (d_reg == '0) begin
                        dividerres <= '1;
                        remainder  <= q_reg;
                        div_zero   <= 1'b1;
                    end else begin
                        dividerres <= q_reg;
                        remainder  <= p_reg[WIDTH-1:0];
                        div_zero   <= 1'b0;
                    end
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a vector table of single divisions plus
// hand-written sequences for reset, ignored start, back-to-back and abort.
module tb_seq_divider;
    import bike_pkg::*;

    logic               clk;
    logic               r;
    logic               start;
    logic [2*DIV_W-1:0] dividerbus;
    logic [DIV_W-1:0]   dividerres;
    logic [DIV_W-1:0]   remainder;
    logic               busy;
    logic               ready;
    logic               div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(DIV_W), .CNT_W(5)) dut (
        .clk        (clk),
        .r          (r),
        .start      (start),
        .dividerbus (dividerbus),
        .dividerres (dividerres),
        .remainder  (remainder),
        .busy       (busy),
        .ready      (ready),
        .div_zero   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dividend;
        logic [15:0] divisor;
        logic [15:0] quo;
        logic [15:0] rem;
        logic        dz;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Step edges until ready is seen (sampled 1 time unit after each edge), bounded.
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready && n < 40);
    endtask

    // Issue a request and leave the bench in the cycle where start is accepted.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        start      = 1'b1;
        dividerbus = {a, b};
        @(posedge clk);
        #1;
        start      = 1'b0;
        dividerbus = $urandom;
    endtask

    task automatic run_op(input vec_t v);
        int n;
        issue(v.dividend, v.divisor);
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        wait_ready(n);
        $display("div %0d / %0d -> q=%0d r=%0d dz=%0b after %0d edges",
                 v.dividend, v.divisor, dividerres, remainder, div_zero, n);
        chk("latency", n, v.lat);
        chk("quotient", {16'b0, dividerres}, {16'b0, v.quo});
        chk("remainder", {16'b0, remainder}, {16'b0, v.rem});
        chk("div_zero", {31'b0, div_zero}, {31'b0, v.dz});
        chk("busy_in_ready", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t v;
        int   n;
        int   pulses;

        vecs[0] = '{16'd36000, 16'd100,   16'd360,   16'd0, 1'b0, 17};
        vecs[1] = '{16'd7,     16'd0,     16'hFFFF,  16'd7, 1'b1, 1};
        vecs[2] = '{16'd5,     16'd7,     16'd0,     16'd5, 1'b0, 17};
        vecs[3] = '{16'd65535, 16'd1,     16'd65535, 16'd0, 1'b0, 17};
        vecs[4] = '{16'd65535, 16'd65535, 16'd1,     16'd0, 1'b0, 17};
        vecs[5] = '{16'd1000,  16'd7,     16'd142,   16'd6, 1'b0, 17};
        vecs[6] = '{16'd0,     16'd9,     16'd0,     16'd0, 1'b0, 17};

        // Reset held for three cycles.
        r = 1'b0;
        start = 1'b0;
        dividerbus = '0;
        repeat (3) @(posedge clk);
        #1;
        r = 1'b1;
        @(posedge clk);
        #1;
        $display("reset: res=%0h rem=%0h busy=%0b ready=%0b dz=%0b",
                 dividerres, remainder, busy, ready, div_zero);
        chk("reset_res", {16'b0, dividerres}, 32'd0);
        chk("reset_rem", {16'b0, remainder}, 32'd0);
        chk("reset_flags", {29'b0, busy, ready, div_zero}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i]);
            @(posedge clk);
            #1;
            chk("ready_one_cycle", {31'b0, ready}, 32'd0);
        end

        // A start arriving while busy is ignored.
        issue(16'd100, 16'd3);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        dividerbus = {16'd9, 16'd3};
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_ready(n);
        $display("ignored start: q=%0d r=%0d after %0d more edges", dividerres, remainder, n);
        chk("ignore_latency", n, 12);
        chk("ignore_quo", {16'b0, dividerres}, 32'd33);
        chk("ignore_rem", {16'b0, remainder}, 32'd1);
        @(posedge clk);
        #1;
        chk("ignore_no_second", {31'b0, busy}, 32'd0);

        // Back-to-back: new request in the ready cycle.
        v = '{16'd20, 16'd4, 16'd5, 16'd0, 1'b0, 17};
        run_op(v);
        issue(16'd50, 16'd5);
        chk("b2b_busy", {30'b0, busy, ready}, 32'd2);
        chk("b2b_held_res", {16'b0, dividerres}, 32'd5);
        wait_ready(n);
        $display("back-to-back: q=%0d r=%0d after %0d edges", dividerres, remainder, n);
        chk("b2b_latency", n, 17);
        chk("b2b_quo", {16'b0, dividerres}, 32'd10);
        chk("b2b_rem", {16'b0, remainder}, 32'd0);

        // Reset in the middle of an operation.
        issue(16'd1000, 16'd7);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        r = 1'b0;
        #1;
        $display("abort: res=%0h rem=%0h busy=%0b ready=%0b", dividerres, remainder, busy, ready);
        chk("abort_res", {16'b0, dividerres}, 32'd0);
        chk("abort_rem", {16'b0, remainder}, 32'd0);
        chk("abort_flags", {29'b0, busy, ready, div_zero}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        r = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (ready) pulses++;
        end
        chk("abort_no_ready", pulses, 0);
        chk("abort_idle", {31'b0, busy}, 32'd0);
        run_op(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
